stream_demux: RTL

Registered 1-to-2 stream demultiplexer with valid/ready handshakes on all sides. A single producer stream is routed, word by word, to output channel 0 or 1 according to a per-word select bit. Each output is driven from its own one-entry holding register. The block is the receiving-side counterpart of the 2:1 selector: it recovers two consumer streams from one shared channel, with backpressure on each output isolated from the other.

---
 rtl/stream_demux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 stream demultiplexer.
// A producer word is steered to out0 or out1 by in_sel and parked in that
// channel's one-entry holding register until its consumer accepts it.
// Optional build macro: STREAM_DEMUX_COUNT_EN adds per-output handshake
// counters (out0_cnt / out1_cnt, CNT_W bits, wrapping).
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]  out0_cnt,
    output logic [CNT_W-1:0]  out1_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t st0_p0, st1_p0;
    ch_state_t st0_nxt, st1_nxt;

    logic [DATA_W-1:0] hold0_p0, hold1_p0;

    logic in_hs;
    logic load0, load1;
    logic drain0, drain1;

    assign out0_valid = (st0_p0 == FULL);
    assign out1_valid = (st1_p0 == FULL);
    assign out0_data  = hold0_p0;
    assign out1_data  = hold1_p0;

    // Handshake decode and next-state logic for both channels; in_ready looks
    // only at the selected channel so a stalled output never blocks the other.
    always_comb begin
        drain0   = out0_valid & out0_ready;
        drain1   = out1_valid & out1_ready;
        in_ready = in_sel ? (~out1_valid | out1_ready)
                          : (~out0_valid | out0_ready);
        in_hs    = in_valid & in_ready;
        load0    = in_hs & ~in_sel;
        load1    = in_hs &  in_sel;

        st0_nxt = st0_p0;
        st1_nxt = st1_p0;

        case (st0_p0)
            EMPTY:   if (load0) st0_nxt = FULL;
            FULL:    if (drain0 && !load0) st0_nxt = EMPTY;
            default: st0_nxt = EMPTY;
        endcase

        case (st1_p0)
            EMPTY:   if (load1) st1_nxt = FULL;
            FULL:    if (drain1 && !load1) st1_nxt = EMPTY;
            default: st1_nxt = EMPTY;
        endcase
    end

    // Channel state registers; reset empties both channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            st0_p0 <= EMPTY;
            st1_p0 <= EMPTY;
        end else begin
            st0_p0 <= st0_nxt;
            st1_p0 <= st1_nxt;
        end
    end

    // Holding registers load only on a handshake addressed to them; reset
    // clears them so a discarded word never lingers on the data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold0_p0 <= '0;
            hold1_p0 <= '0;
        end else begin
            if (load0) hold0_p0 <= in_data;
            if (load1) hold1_p0 <= in_data;
        end
    end

`ifdef STREAM_DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt0_p0, cnt1_p0;

    assign out0_cnt = cnt0_p0;
    assign out1_cnt = cnt1_p0;

    // Completed output handshakes per channel, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_p0 <= '0;
            cnt1_p0 <= '0;
        end else begin
            if (drain0) cnt0_p0 <= cnt0_p0 + 1'b1;
            if (drain1) cnt1_p0 <= cnt1_p0 + 1'b1;
        end
    end
`else
    // CNT_W only sizes the counters; without them it has nothing to drive.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
